// File: rtl/regfile_wb_sched_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched_pkg
//   Shared sizing constants and types for the register-file write-back
//   scheduler, its interface and its scoreboard.
//   DW      : data width (WORD bytes of WIDTH bits)
//   NREG    : number of architectural registers
//   PC_ADDR : register index that aliases the program counter
//   CMAX    : saturation value of a per-register pending-writer counter
//   rr_e    : round-robin pointer, names the producer preferred on a tie
// -----------------------------------------------------------------------------
package regfile_wb_sched_pkg;
   localparam int WORD       = 4;
   localparam int WIDTH      = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int CNT_WIDTH  = 2;
   localparam int DW         = WORD * WIDTH;
   localparam int NREG       = 1 << ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DW-1:0]         data_t;
   typedef logic [CNT_WIDTH-1:0]  cnt_t;

   localparam addr_t PC_ADDR = addr_t'(NREG - 1);
   localparam cnt_t  CMAX    = cnt_t'((1 << CNT_WIDTH) - 1);

   typedef enum logic {
      RR_MEM = 1'b0,
      RR_ALU = 1'b1
   } rr_e;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched_if
//   Bundles the producer, issue, hazard and regfile-write signals of the
//   write-back scheduler.
//   Handshake: a request transfers in a cycle where x_valid && x_ready are
//   both high at the rising edge. x_ready is combinational and may depend on
//   x_valid; a producer holds valid/addr/data stable until it sees ready.
//   slave  : the scheduler side (drives readys, hazards, regfile write)
//   master : the pipeline side (drives requests, issue and read addresses)
//   rr_state is a debug view of the arbiter's round-robin pointer.
// -----------------------------------------------------------------------------
interface regfile_wb_sched_if;
   import regfile_wb_sched_pkg::*;

   logic  alu_valid, alu_ready;
   addr_t alu_addr;
   data_t alu_data;
   logic  mem_valid, mem_ready;
   addr_t mem_addr;
   data_t mem_data;
   logic  iss_valid, iss_ready;
   addr_t iss_addr;
   addr_t rd1, rd2;
   logic  haz1, haz2;
   logic  we;
   addr_t wa;
   data_t wd;
   logic  pc_wr;
   rr_e   rr_state;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  iss_valid, iss_addr, rd1, rd2,
      output alu_ready, mem_ready, iss_ready, haz1, haz2,
      output we, wa, wd, pc_wr, rr_state
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output iss_valid, iss_addr, rd1, rd2,
      input  alu_ready, mem_ready, iss_ready, haz1, haz2,
      input  we, wa, wd, pc_wr, rr_state
   );
endinterface

// File: rtl/regfile_wb_sched_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched_scoreboard
//   One saturating pending-writer counter per register. An accepted issue
//   increments, a write-back grant (commit) decrements. Two hazard read ports.
//   clk, rst        : clock, synchronous active-high reset (clears counters)
//   iss_valid_i/addr: issue request; iss_ready_o low when counter is at CMAX
//   commit_i/addr   : write-back grant this cycle
//   rd1_i, rd2_i    : decode read addresses; haz1_o/haz2_o flag pending writers
// -----------------------------------------------------------------------------
module regfile_wb_sched_scoreboard
   import regfile_wb_sched_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  iss_valid_i,
   input  addr_t iss_addr_i,
   output logic  iss_ready_o,
   input  logic  commit_i,
   input  addr_t commit_addr_i,
   input  addr_t rd1_i,
   input  addr_t rd2_i,
   output logic  haz1_o,
   output logic  haz2_o
);
   cnt_t cnt_q [NREG];
   cnt_t cnt_d [NREG];
   logic iss_fire;

   assign iss_ready_o = !rst && (cnt_q[iss_addr_i] != CMAX);
   assign iss_fire    = iss_valid_i && iss_ready_o;

   // Hazards read the current count, so a commit in flight still flags:
   // its data only reaches the regfile on the following cycle.
   assign haz1_o = (cnt_q[rd1_i] != '0);
   assign haz2_o = (cnt_q[rd2_i] != '0);

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (iss_fire && iss_addr_i == addr_t'(r)) begin
            // Issue and commit to the same register cancel out.
            if (!(commit_i && commit_addr_i == addr_t'(r)))
               cnt_d[r] = cnt_q[r] + cnt_t'(1);
         end else if (commit_i && commit_addr_i == addr_t'(r) && cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         cnt_q <= cnt_d;
         // A write-back to a register nobody issued is a producer bug.
         if (commit_i) assert (cnt_q[commit_addr_i] != '0);
      end
   end
endmodule

// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
//   Write-back scheduler: round-robin arbitration of the single regfile write
//   port between the ALU and load producers, registered we/wa/wd, PC-write
//   decode, and a pending-writer scoreboard for RAW hazard detection.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : regfile_wb_sched_if.slave (requests, issue, hazards, regfile write)
// -----------------------------------------------------------------------------
module regfile_wb_sched
   import regfile_wb_sched_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   regfile_wb_sched_if.slave  bus
);
   rr_e   rr_q, rr_d;
   logic  gnt_alu, gnt_mem, commit;
   addr_t commit_addr;
   data_t commit_data;
   logic  we_q, pc_wr_q;
   addr_t wa_q;
   data_t wd_q;

   // Arbiter: a lone request wins outright; on a tie the pointer decides and
   // then flips, so the pointer only moves on contended grants.
   always_comb begin
      gnt_alu = 1'b0;
      gnt_mem = 1'b0;
      rr_d    = rr_q;
      if (!rst) begin
         if (bus.alu_valid && bus.mem_valid) begin
            if (rr_q == RR_ALU) begin
               gnt_alu = 1'b1;
               rr_d    = RR_MEM;
            end else begin
               gnt_mem = 1'b1;
               rr_d    = RR_ALU;
            end
         end else begin
            gnt_alu = bus.alu_valid;
            gnt_mem = bus.mem_valid;
         end
      end
   end

   assign commit      = gnt_alu || gnt_mem;
   assign commit_addr = gnt_alu ? bus.alu_addr : bus.mem_addr;
   assign commit_data = gnt_alu ? bus.alu_data : bus.mem_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= RR_MEM;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         pc_wr_q <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         we_q    <= commit;
         pc_wr_q <= commit && (commit_addr == PC_ADDR);
         // Address/data hold on idle cycles; only we drops.
         if (commit) begin
            wa_q <= commit_addr;
            wd_q <= commit_data;
         end
      end
   end

   assign bus.alu_ready = gnt_alu;
   assign bus.mem_ready = gnt_mem;
   assign bus.we        = we_q;
   assign bus.wa        = wa_q;
   assign bus.wd        = wd_q;
   assign bus.pc_wr     = pc_wr_q;
   assign bus.rr_state  = rr_q;

   regfile_wb_sched_scoreboard u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .iss_valid_i   (bus.iss_valid),
      .iss_addr_i    (bus.iss_addr),
      .iss_ready_o   (bus.iss_ready),
      .commit_i      (commit),
      .commit_addr_i (commit_addr),
      .rd1_i         (bus.rd1),
      .rd2_i         (bus.rd2),
      .haz1_o        (bus.haz1),
      .haz2_o        (bus.haz2)
   );
endmodule

// File: tb/tb_regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_sched
//   Directed steps followed by a randomized phase, all compared cycle by cycle
//   against a behavioural model: per-register pending counts as plain integers,
//   a "who wins the next tie" bit, and the expected regfile write of the
//   previous cycle.
// -----------------------------------------------------------------------------
module tb_regfile_wb_sched;
   import regfile_wb_sched_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wb_sched_if bus ();

   regfile_wb_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   int          cnt_m [NREG];
   bit          alu_wins_tie;
   logic        we_m, pc_m;
   logic [3:0]  wa_m;
   logic [31:0] wd_m;
   bit          cnt_known = 1'b0;

   // combinational outputs captured at the last negedge
   logic last_alu_ready, last_mem_ready, last_iss_ready, last_haz1, last_haz2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check combinational outputs at negedge, advance the model at
   // posedge, check registered outputs 1 time unit later.
   task automatic cycle();
      bit ga, gm, iok;
      logic av, mv, iv;
      logic [3:0] aa, ma, ia;
      logic [31:0] ad, md;
      @(negedge clk);
      av = bus.alu_valid; aa = bus.alu_addr; ad = bus.alu_data;
      mv = bus.mem_valid; ma = bus.mem_addr; md = bus.mem_data;
      iv = bus.iss_valid; ia = bus.iss_addr;
      if (rst) begin
         ga = 0; gm = 0; iok = 0;
      end else begin
         ga  = av && (!mv || alu_wins_tie);
         gm  = mv && (!av || !alu_wins_tie);
         iok = cnt_m[ia] < 3;
      end
      last_alu_ready = bus.alu_ready;
      last_mem_ready = bus.mem_ready;
      last_iss_ready = bus.iss_ready;
      last_haz1      = bus.haz1;
      last_haz2      = bus.haz2;
      chk("alu_ready", bus.alu_ready, ga);
      chk("mem_ready", bus.mem_ready, gm);
      chk("iss_ready", bus.iss_ready, iok);
      if (cnt_known) begin
         chk("haz1", bus.haz1, cnt_m[bus.rd1] != 0);
         chk("haz2", bus.haz2, cnt_m[bus.rd2] != 0);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
         alu_wins_tie = 0;
         we_m = 0; wa_m = 0; wd_m = 0; pc_m = 0;
         cnt_known = 1;
      end else begin
         if (ga || gm) begin
            we_m = 1;
            wa_m = ga ? aa : ma;
            wd_m = ga ? ad : md;
         end else begin
            we_m = 0;
         end
         pc_m = we_m && (wa_m == 4'd15);
         if (av && mv) alu_wins_tie = !alu_wins_tie;
         if (iv && iok) cnt_m[ia] = cnt_m[ia] + 1;
         if ((ga || gm) && cnt_m[wa_m] > 0) cnt_m[wa_m] = cnt_m[wa_m] - 1;
      end
      chk("we", bus.we, we_m);
      chk("wa", bus.wa, wa_m);
      chk("wd", bus.wd, wd_m);
      chk("pc_wr", bus.pc_wr, pc_m);
      chk("rr_state", bus.rr_state, alu_wins_tie);
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 0; bus.mem_valid = 0; bus.iss_valid = 0;
   endtask

   // Random register that still has an unclaimed pending write.
   function automatic int pick_reg(input logic other_v, input logic [3:0] other_a);
      for (int t = 0; t < 32; t++) begin
         int r = $urandom_range(0, 15);
         int avail = cnt_m[r] - ((other_v && other_a == 4'(r)) ? 1 : 0);
         if (avail > 0) return r;
      end
      return -1;
   endfunction

   initial begin
      int exp_wa [4];
      int r;
      exp_wa = '{2, 1, 2, 1};

      bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
      bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
      bus.iss_valid = 0; bus.iss_addr = 0; bus.rd1 = 0; bus.rd2 = 0;
      alu_wins_tie = 0; we_m = 0; wa_m = 0; wd_m = 0; pc_m = 0;
      for (int i = 0; i < NREG; i++) cnt_m[i] = 0;

      // reset held two cycles with an ALU request present
      rst = 1;
      bus.alu_valid = 1; bus.alu_addr = 3; bus.alu_data = 32'h1234_5678;
      cycle();
      cycle();
      chk("rst_alu_ready", last_alu_ready, 0);
      chk("rst_haz1", last_haz1, 0);
      chk("rst_haz2", last_haz2, 0);
      chk("rst_we", bus.we, 0);
      chk("rst_wa", bus.wa, 0);
      chk("rst_wd", bus.wd, 0);
      rst = 0;
      idle_inputs();

      // single ALU write to r3
      bus.iss_valid = 1; bus.iss_addr = 3;
      cycle();
      idle_inputs();
      bus.alu_valid = 1; bus.alu_addr = 3; bus.alu_data = 32'hDEAD_BEEF;
      cycle();
      chk("alu_alone_ready", last_alu_ready, 1);
      chk("alu_alone_we", bus.we, 1);
      chk("alu_alone_wa", bus.wa, 3);
      chk("alu_alone_wd", bus.wd, 32'hDEAD_BEEF);
      idle_inputs();
      cycle();
      chk("idle_we", bus.we, 0);
      chk("idle_wd_hold", bus.wd, 32'hDEAD_BEEF);

      // contention: MEM first after reset, then alternate
      foreach (exp_wa[i]) begin
         bus.iss_valid = 1; bus.iss_addr = (i < 2) ? 4'd1 : 4'd2;
         cycle();
      end
      idle_inputs();
      bus.alu_valid = 1; bus.alu_addr = 1; bus.alu_data = 32'hA1A1_0001;
      bus.mem_valid = 1; bus.mem_addr = 2; bus.mem_data = 32'hB2B2_0002;
      foreach (exp_wa[i]) begin
         cycle();
         chk("rr_wa", bus.wa, exp_wa[i]);
      end
      idle_inputs();

      // saturate r5, check hazard, drain
      bus.rd1 = 5;
      bus.iss_valid = 1; bus.iss_addr = 5;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("sat_iss_ready", last_iss_ready, (i < 3) ? 1 : 0);
         if (i == 0) chk("no_self_haz", last_haz1, 0);
      end
      idle_inputs();
      bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_data = 32'h5555_0000;
      for (int i = 0; i < 3; i++) begin
         bus.alu_data = 32'h5555_0000 + 32'(i);
         cycle();
         chk("drain_haz1", last_haz1, 1);
      end
      idle_inputs();
      cycle();
      chk("drained_haz1", last_haz1, 0);

      // same-cycle issue and commit on r7
      bus.rd2 = 7;
      bus.iss_valid = 1; bus.iss_addr = 7;
      cycle();
      bus.mem_valid = 1; bus.mem_addr = 7; bus.mem_data = 32'h7777_7777;
      cycle();
      chk("ic_haz2", last_haz2, 1);
      chk("ic_mem_ready", last_mem_ready, 1);
      idle_inputs();
      cycle();
      chk("ic_haz2_after", last_haz2, 1);
      bus.mem_valid = 1; bus.mem_addr = 7; bus.mem_data = 32'h7777_0000;
      cycle();
      idle_inputs();
      cycle();
      chk("ic_haz2_clear", last_haz2, 0);

      // PC write
      bus.iss_valid = 1; bus.iss_addr = 15;
      cycle();
      idle_inputs();
      bus.mem_valid = 1; bus.mem_addr = 15; bus.mem_data = 32'h100;
      cycle();
      chk("pc_we", bus.we, 1);
      chk("pc_wa", bus.wa, 15);
      chk("pc_wd", bus.wd, 32'h100);
      chk("pc_wr", bus.pc_wr, 1);
      idle_inputs();
      cycle();
      chk("pc_wr_drop", bus.pc_wr, 0);

      // randomized phase; producers hold requests until accepted
      for (int n = 0; n < 400; n++) begin
         if (bus.alu_valid && last_alu_ready) bus.alu_valid = 0;
         if (bus.mem_valid && last_mem_ready) bus.mem_valid = 0;
         if (n == 0) begin bus.alu_valid = 0; bus.mem_valid = 0; end
         if (!bus.alu_valid && $urandom_range(0, 1) == 1) begin
            r = pick_reg(bus.mem_valid, bus.mem_addr);
            if (r >= 0) begin
               bus.alu_valid = 1; bus.alu_addr = 4'(r); bus.alu_data = $urandom();
            end
         end
         if (!bus.mem_valid && $urandom_range(0, 1) == 1) begin
            r = pick_reg(bus.alu_valid, bus.alu_addr);
            if (r >= 0) begin
               bus.mem_valid = 1; bus.mem_addr = 4'(r); bus.mem_data = $urandom();
            end
         end
         bus.iss_valid = ($urandom_range(0, 2) != 0);
         bus.iss_addr  = 4'($urandom_range(0, 15));
         bus.rd1       = 4'($urandom_range(0, 15));
         bus.rd2       = 4'($urandom_range(0, 15));
         cycle();
      end
      idle_inputs();

      // reset mid-stream clears every counter
      for (int i = 0; i < 4; i++) begin
         bus.iss_valid = 1; bus.iss_addr = 4'(2 * i + 4);
         cycle();
      end
      rst = 1;
      cycle();
      rst = 0;
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         bus.rd1 = 4'(2 * i); bus.rd2 = 4'(2 * i + 1);
         cycle();
         chk("rst_clr_haz1", last_haz1, 0);
         chk("rst_clr_haz2", last_haz2, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
